// File: rtl/ins_word_packer_if.sv
// Insert/flush request and RAM write bus for ins_word_packer.
// Widths follow the packer parameters; the packer uses the slave modport.
interface ins_word_packer_if #(
  parameter int unsigned SYM_W         = 2,
  parameter int unsigned SYMS_PER_WORD = 4,
  parameter int unsigned ADDR_W        = 6
);
  localparam int unsigned DataW = SYM_W * SYMS_PER_WORD;
  localparam int unsigned FillW = $clog2(SYMS_PER_WORD) + 1;

  logic              en_ins;
  logic [SYM_W-1:0]  sym_in;
  logic              flush;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DataW-1:0]  wr_data;
  logic [FillW-1:0]  wr_fill;
  logic              hit;
  logic              full;
  logic              overflow;

  modport master (
    output en_ins, sym_in, flush,
    input  wr_en, wr_addr, wr_data, wr_fill, hit, full, overflow
  );

  modport slave (
    input  en_ins, sym_in, flush,
    output wr_en, wr_addr, wr_data, wr_fill, hit, full, overflow
  );
endinterface

// File: rtl/ins_word_packer.sv
// Packs SYMS_PER_WORD symbols per RAM word and emits registered RAM writes with address tracking.
// Partial-word flush is compiled in only when INS_PACKER_FLUSH_EN is defined.
module ins_word_packer #(
  parameter int unsigned SYM_W         = 2,
  parameter int unsigned SYMS_PER_WORD = 4,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned ADDR_W        = 6
) (
  input logic               clk,
  input logic               rst,
  ins_word_packer_if.slave  bus
);
  localparam int unsigned DataW = SYM_W * SYMS_PER_WORD;
  localparam int unsigned CntW  = $clog2(SYMS_PER_WORD);
  localparam int unsigned FillW = CntW + 1;
  localparam int unsigned WcntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0]  LastSlot = CntW'(SYMS_PER_WORD - 1);
  localparam logic [WcntW-1:0] LastWord = WcntW'(DEPTH - 1);

  typedef enum logic [0:0] {StFill, StFull} state_e;
  state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DataW-1:0]  acc_q, acc_d;
  logic [WcntW-1:0]  waddr_q, waddr_d;
  logic              wr_en_q, wr_en_d;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DataW-1:0]  wr_data_q, wr_data_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
`ifdef INS_PACKER_FLUSH_EN
  logic [FillW-1:0]  wr_fill_q, wr_fill_d;
`endif

  logic             ins, complete, do_flush, do_write;
  logic [DataW-1:0] acc_ins;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFill;
      cnt_q      <= '0;
      acc_q      <= '0;
      waddr_q    <= '0;
      wr_en_q    <= 1'b0;
      hit_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef INS_PACKER_FLUSH_EN
      wr_fill_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      waddr_q    <= waddr_d;
      wr_en_q    <= wr_en_d;
      hit_q      <= hit_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
`ifdef INS_PACKER_FLUSH_EN
      wr_fill_q  <= wr_fill_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StFill && do_write && waddr_q == LastWord) state_d = StFull;
  end

  always_comb begin
    ins      = (state_q == StFill) && bus.en_ins;
    complete = ins && (cnt_q == LastSlot);
    acc_ins  = acc_q;
    acc_ins[cnt_q*SYM_W +: SYM_W] = bus.sym_in;
`ifdef INS_PACKER_FLUSH_EN
    // A same-cycle insert counts toward the flushed word, so an empty slot count is not empty then.
    do_flush = (state_q == StFill) && bus.flush && !complete && (ins || cnt_q != '0);
`else
    do_flush = 1'b0;
`endif
    do_write   = complete || do_flush;

    cnt_d      = cnt_q;
    acc_d      = acc_q;
    waddr_d    = waddr_q;
    wr_en_d    = 1'b0;
    hit_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    full_d     = full_q | (do_write && waddr_q == LastWord);
    overflow_d = overflow_q | ((state_q == StFull) && bus.en_ins);
`ifdef INS_PACKER_FLUSH_EN
    wr_fill_d  = wr_fill_q;
`endif

    if (do_write) begin
      wr_en_d   = 1'b1;
      hit_d     = complete;
      wr_addr_d = ADDR_W'(waddr_q);
      wr_data_d = ins ? acc_ins : acc_q;
      cnt_d     = '0;
      acc_d     = '0;
      waddr_d   = waddr_q + WcntW'(1);
`ifdef INS_PACKER_FLUSH_EN
      if (complete)  wr_fill_d = FillW'(SYMS_PER_WORD);
      else if (ins)  wr_fill_d = FillW'(cnt_q) + FillW'(1);
      else           wr_fill_d = FillW'(cnt_q);
`endif
    end else if (ins) begin
      cnt_d = cnt_q + CntW'(1);
      acc_d = acc_ins;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.hit      = hit_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;
`ifdef INS_PACKER_FLUSH_EN
  assign bus.wr_fill  = wr_fill_q;
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign bus.wr_fill  = FillW'(SYMS_PER_WORD);
`endif
endmodule

// File: tb/tb_ins_word_packer.sv
// Scoreboard bench for ins_word_packer (SYM_W=2, SYMS_PER_WORD=4, DEPTH=4).
// Flush expectations follow whether INS_PACKER_FLUSH_EN is defined.
module tb_ins_word_packer;
  localparam int unsigned SW = 2, SPW = 4, DEP = 4, AW = 2, DW = 8, FW = 3;
`ifdef INS_PACKER_FLUSH_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [FW-1:0] fill;
    logic          hit;
    logic          full;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  wr_t  exp_q[$];
  wr_t  obs_q[$];
  wr_t  e, o, w;

  always #5 clk = ~clk;

  ins_word_packer_if #(.SYM_W(SW), .SYMS_PER_WORD(SPW), .ADDR_W(AW)) bus ();

  ins_word_packer #(
    .SYM_W(SW), .SYMS_PER_WORD(SPW), .DEPTH(DEP), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // One clock: drive inputs, let the edge sample them, then record any write it produced.
  task automatic cycle(input logic r, input logic en, input logic [SW-1:0] s, input logic f);
    rst = r;
    bus.en_ins = en;
    bus.sym_in = s;
    bus.flush = f;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.wr_en === 1'b1) begin
      w.cyc = cyc; w.addr = bus.wr_addr; w.data = bus.wr_data;
      w.fill = bus.wr_fill; w.hit = bus.hit; w.full = bus.full;
      obs_q.push_back(w);
    end
    rst = 1'b0; bus.en_ins = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic push_exp(input int a, input logic [DW-1:0] d, input int fl, input logic h,
                          input logic fu);
    w.cyc = cyc; w.addr = AW'(a); w.data = d; w.fill = FW'(fl); w.hit = h; w.full = fu;
    exp_q.push_back(w);
  endtask

  task automatic test_word();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, SW'(i), 0);
    push_exp(0, 8'hE4, 4, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL word_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL word_write: got cyc=%0d addr=%0d data=%h fill=%0d hit=%b full=%b, want cyc=%0d addr=%0d data=%h fill=%0d hit=%b full=%b", o.cyc, o.addr, o.data, o.fill, o.hit, o.full, e.cyc, e.addr, e.data, e.fill, e.hit, e.full);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_flush();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 2'd3, 0);
    cycle(0, 1, 2'd2, 0);
    cycle(0, 0, 0, 1);
    if (FE) push_exp(0, 8'h0B, 2, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    if (!FE) begin
      cycle(0, 1, 2'd0, 0);
      cycle(0, 1, 2'd0, 0);
      push_exp(0, 8'h0B, 4, 1, 0);
    end
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL flush_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL flush_write: got cyc=%0d addr=%0d data=%h fill=%0d hit=%b full=%b, want cyc=%0d addr=%0d data=%h fill=%0d hit=%b full=%b", o.cyc, o.addr, o.data, o.fill, o.hit, o.full, e.cyc, e.addr, e.data, e.fill, e.hit, e.full);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_simultaneous();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 2'd1, 0);
    cycle(0, 1, 2'd2, 1);
    push_exp(0, 8'h95, 4, 1, 0);
    // Partial word: insert+flush together writes both symbols in one flush.
    cycle(0, 1, 2'd3, 0);
    cycle(0, 1, 2'd1, 1);
    if (FE) push_exp(1, 8'h07, 2, 0, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL simul_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL simul_write: got cyc=%0d addr=%0d data=%h fill=%0d hit=%b full=%b, want cyc=%0d addr=%0d data=%h fill=%0d hit=%b full=%b", o.cyc, o.addr, o.data, o.fill, o.hit, o.full, e.cyc, e.addr, e.data, e.fill, e.hit, e.full);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_depth();
    logic [DW-1:0] word;
    logic [SW-1:0] s;
    cycle(1, 0, 0, 0);
    word = '0;
    for (int i = 0; i < 16; i++) begin
      s = SW'($urandom_range(0, 3));
      cycle(0, 1, s, 0);
      word[2*(i%4) +: 2] = s;
      if (i % 4 == 3) begin
        push_exp(i / 4, word, 4, 1, i == 15);
        word = '0;
      end
      if (i == 11) begin
        checks++;
        if (bus.full !== 1'b0) $display("FAIL full_early: got %b, want 0", bus.full);
        else passed++;
      end
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (bus.full !== 1'b1) $display("FAIL full_set: got %b, want 1", bus.full);
    else passed++;
    checks++;
    if (bus.overflow !== 1'b0) $display("FAIL overflow_early: got %b, want 0", bus.overflow);
    else passed++;
    cycle(0, 1, 2'd2, 0);
    checks++;
    if (bus.overflow !== 1'b1) $display("FAIL overflow_set: got %b, want 1", bus.overflow);
    else passed++;
    cycle(0, 0, 0, 1);
    cycle(0, 1, 2'd1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    checks++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b1)
      $display("FAIL full_hold: got full=%b overflow=%b, want 1 1", bus.full, bus.overflow);
    else passed++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL depth_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL depth_write: got cyc=%0d addr=%0d data=%h fill=%0d hit=%b full=%b, want cyc=%0d addr=%0d data=%h fill=%0d hit=%b full=%b", o.cyc, o.addr, o.data, o.fill, o.hit, o.full, e.cyc, e.addr, e.data, e.fill, e.hit, e.full);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset();
    logic [FW-1:0] fill_rst;
    fill_rst = FE ? FW'(0) : FW'(SPW);
    cycle(1, 0, 0, 0);
    checks++;
    if (bus.wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b, want 0", bus.wr_en); else passed++;
    checks++;
    if (bus.hit !== 1'b0) $display("FAIL rst_hit: got %b, want 0", bus.hit); else passed++;
    checks++;
    if (bus.wr_addr !== '0) $display("FAIL rst_wr_addr: got %0d, want 0", bus.wr_addr);
    else passed++;
    checks++;
    if (bus.wr_data !== '0) $display("FAIL rst_wr_data: got %h, want 00", bus.wr_data);
    else passed++;
    checks++;
    if (bus.wr_fill !== fill_rst)
      $display("FAIL rst_wr_fill: got %0d, want %0d", bus.wr_fill, fill_rst);
    else passed++;
    checks++;
    if (bus.full !== 1'b0) $display("FAIL rst_full: got %b, want 0", bus.full); else passed++;
    checks++;
    if (bus.overflow !== 1'b0) $display("FAIL rst_overflow: got %b, want 0", bus.overflow);
    else passed++;
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 2'd1, 0);
    cycle(0, 1, 2'd2, 0);
    // Reset wins over a same-cycle insert and flush.
    cycle(1, 1, 2'd3, 1);
    cycle(0, 1, 2'd0, 0);
    cycle(0, 1, 2'd0, 0);
    cycle(0, 1, 2'd0, 0);
    cycle(0, 1, 2'd1, 0);
    push_exp(0, 8'h40, 4, 1, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL rstmid_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL rstmid_write: got cyc=%0d addr=%0d data=%h fill=%0d hit=%b full=%b, want cyc=%0d addr=%0d data=%h fill=%0d hit=%b full=%b", o.cyc, o.addr, o.data, o.fill, o.hit, o.full, e.cyc, e.addr, e.data, e.fill, e.hit, e.full);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    bus.en_ins = 1'b0;
    bus.sym_in = '0;
    bus.flush = 1'b0;
    cycle(1, 0, 0, 0);
    obs_q.delete();
    test_word();
    test_flush();
    test_simultaneous();
    test_depth();
    test_reset();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
